adc_interface_ad7862: RTL and testbench
=======================================

# adc_interface_ad7862

Read-side counterpart of the AD5725 DAC driver on the memory board. Accepts the same `cs`/`op`/`addr` command strobe from the host opcode decoder. Runs one conversion on a parallel-output 12-bit ADC (CONVST/BUSY/CS/RD, 2-channel mux via A0). Returns the sample on `data_out` with a one-cycle `valid` pulse. Used to read back cell current/voltage after each DAC write.

## Interface
- `T_CONVST`, 2: cycles CONVST_N is held low (≥1)
- `T_RD`, 3: cycles RD_N is held low before DB is sampled (≥1)
- `TIMEOUT`, 255: max cycles waited for each BUSY edge (≤255)

- `clk` input 1: system clock
- `rst` input 1: reset, synchronous, active-high
- `cs` input 1: command strobe; qualifies `op`, `addr`
- `op` input 4: bit0 soft reset (same as `rst`), bit1 start conversion; bits 3:2 ignored
- `addr` input 8: bit0 selects ADC channel (A0); bits 7:1 ignored
- `rdy` output 1: high when idle and able to accept a start
- `valid` output 1: one-cycle pulse when `data_out` is updated
- `err` output 1: sticky BUSY-timeout flag; cleared on the next accepted start
- `state` output 4: current FSM state, for debug readback
- `data_out` output 16: last sample, zero-extended {4'b0, DB}
- `CONVST_N` output 1: ADC convert start, active-low
- `CS_N` output 1: ADC chip select, active-low
- `RD_N` output 1: ADC read strobe, active-low
- `A0` output 1: ADC channel select
- `BUSY` input 1: ADC busy, asynchronous
- `DB` input 12: ADC parallel data

## Operation
- Internal reset: `rst | (cs & op[0])`.
- While reset is asserted:
  - state=RESET; CONVST_N=CS_N=RD_N=1; A0=0
  - rdy=0, valid=0, err=0, data_out=0
  - counter=0
- `BUSY` passes through a 2-flop synchronizer (`busy_s`). Only `busy_s` is used.
- Start: `cs & op[1]`. Accepted only in IDLE; ignored in any other state (no queuing).

FSM (encoding in package):
- RESET(1): the first cycle with reset deasserted → IDLE, rdy←1.
- IDLE(0): on start: A0←addr[0], CONVST_N←0, rdy←0, err←0, counter←0 → CONV.
- CONV(2): when counter==T_CONVST−1: CONVST_N←1, counter←0 → WAIT_HI.
- WAIT_HI(3):
  - busy_s==1 → WAIT_LO, counter←0.
  - Else if counter==TIMEOUT → ERR.
- WAIT_LO(4):
  - busy_s==0 → READ, counter←0.
  - Else if counter==TIMEOUT → ERR.
- READ(5):
  - counter 0: CS_N←0.
  - counter 1: RD_N←0.
  - counter 1+T_RD: data_out←{4'b0,DB}; RD_N←1 → DONE.
- DONE(6): CS_N←1, valid←1 (one cycle), rdy←1 → IDLE.
- ERR(7): err←1, rdy←1, CONVST_N=CS_N=RD_N=1, data_out unchanged, no valid → IDLE.

Other rules:
- Counter is 8-bit and cleared on every state change. It never wraps, because TIMEOUT≤255.
- A0 is held from CONV entry until the next accepted start.

## Timing
- Start accepted at edge E: CONVST_N low from E through E+T_CONVST.
- BUSY detection latency: 2 cycles (synchronizer) + 1 cycle (FSM).
- BUSY falling edge at cycle B (after sync) → CS_N low at B+1, RD_N low at B+2, DB sampled at B+2+T_RD.
  - External DB must be stable ≥1 cycle before that sample edge.
- valid and rdy rise together one cycle after the sample edge.
- With defaults and a 10-cycle BUSY high: ~21 cycles from start to valid.
- BUSY already high at WAIT_HI entry (previous conversion still running): treated as the rising edge; proceeds to WAIT_LO.
- Reset mid-conversion: all strobes deassert the next edge; the ADC may finish on its own; no output is produced.
- Start and soft reset in the same `cs` cycle: reset wins.

## Structure
- `adc_pkg`: state localparams (RESET…ERR, 4-bit), default timing constants.
- Sub-module `sync2` (2-flop synchronizer, 1-bit, reset to 0) for BUSY; reusable for other async status pins.
- The remainder is a single FSM + counter in `adc_interface_ad7862`.

## Test plan
- Reset: assert rst 3 cycles → all strobes 1, rdy=0, data_out=0. Release → rdy=1 after 1 cycle, state=0.
- Normal read: start with addr=8'h01, BUSY high 10 cycles, DB=12'hA5C → A0=1, CONVST_N low exactly 2 cycles, one valid pulse, data_out=16'h0A5C, RD_N low exactly 3 cycles inside CS_N low.
- Timeout: BUSY held 0 → after 256 cycles in WAIT_HI, err=1, rdy=1, valid never pulses, data_out keeps 16'h0A5C.
- Stuck BUSY: BUSY held 1 → err=1 via WAIT_LO timeout. Next start (BUSY normal, DB=12'h123) → err clears at accept, data_out=16'h0123.
- Start while busy: extra `cs&op[1]` during WAIT_LO → ignored, exactly one valid.
- Soft reset mid-READ: `cs` with op=4'b0011 while CS_N=0 → next edge CS_N=RD_N=1, state=RESET, no valid, data_out=0.

Source files
------------

// File: rtl/adc_interface_ad7862_pkg.sv
// ---------------------------------------------------------------------------
// adc_interface_ad7862_pkg
//
// Shared definitions for the AD7862 read-back interface:
//   - adc_state_e : FSM state encoding, also visible on the debug `state` port
//   - default timing constants for CONVST width, RD width and BUSY timeout
//   - field widths and opcode bit positions of the host command strobe
//   - zext_sample : packs a raw 12-bit conversion into the 16-bit result word
// ---------------------------------------------------------------------------
package adc_interface_ad7862_pkg;

    // The numeric values are visible to software through the debug
    // `state` port, so they are fixed explicitly.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RESET   = 4'd1,
        ST_CONV    = 4'd2,
        ST_WAIT_HI = 4'd3,
        ST_WAIT_LO = 4'd4,
        ST_READ    = 4'd5,
        ST_DONE    = 4'd6,
        ST_ERR     = 4'd7
    } adc_state_e;

    // Default timing, in clk cycles.
    localparam int unsigned T_CONVST_DEF = 2;
    localparam int unsigned T_RD_DEF     = 3;
    localparam int unsigned TIMEOUT_DEF  = 255;

    // Field widths.
    localparam int CNT_W  = 8;
    localparam int DB_W   = 12;
    localparam int DATA_W = 16;
    localparam int OP_W   = 4;
    localparam int ADDR_W = 8;
    localparam int STATE_W = 4;

    // Opcode bit positions within `op`.
    localparam int OP_SOFT_RST_BIT = 0;
    localparam int OP_START_BIT    = 1;

    // The upper nibble of the result word is always zero.
    function automatic logic [DATA_W-1:0] zext_sample(input logic [DB_W-1:0] db);
        return {{(DATA_W - DB_W){1'b0}}, db};
    endfunction

endpackage

// File: rtl/adc_interface_ad7862_if.sv
// ---------------------------------------------------------------------------
// adc_interface_ad7862_if
//
// Host-side command/result bus of the AD7862 read-back interface.
//   cs       : command strobe, qualifies op and addr
//   op       : bit0 soft reset, bit1 start conversion, bits 3:2 unused
//   addr     : bit0 selects the ADC channel (A0), bits 7:1 unused
//   rdy      : idle and able to accept a start
//   valid    : one-cycle pulse when data_out is updated
//   err      : sticky BUSY-timeout flag
//   state    : current FSM state (debug)
//   data_out : last sample, zero-extended
//
// Modports:
//   master : the host opcode decoder (drives the command)
//   slave  : the ADC interface block (returns status and data)
// ---------------------------------------------------------------------------
interface adc_interface_ad7862_if;
    import adc_interface_ad7862_pkg::*;

    logic                cs;
    logic [OP_W-1:0]     op;
    logic [ADDR_W-1:0]   addr;
    logic                rdy;
    logic                valid;
    logic                err;
    logic [STATE_W-1:0]  state;
    logic [DATA_W-1:0]   data_out;

    modport master (
        output cs, op, addr,
        input  rdy, valid, err, state, data_out
    );

    modport slave (
        input  cs, op, addr,
        output rdy, valid, err, state, data_out
    );

endinterface

// File: rtl/adc_interface_ad7862_sync2.sv
// ---------------------------------------------------------------------------
// sync2
//
// Two-flop synchronizer for a single asynchronous status pin. Both stages
// clear to 0 on reset, so a pin that is high across reset is seen as a
// fresh rising edge two cycles after reset is released.
//
// Ports:
//   clk : destination clock
//   rst : synchronous, active-high reset
//   d   : asynchronous input
//   q   : synchronized output, two cycles of latency
// ---------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/adc_interface_ad7862.sv
// ---------------------------------------------------------------------------
// adc_interface_ad7862
//
// Read-side companion to the AD5725 DAC driver. A start command from the host
// opcode decoder runs one conversion on an AD7862-style parallel ADC
// (CONVST_N / BUSY / CS_N / RD_N, channel select on A0) and returns the
// 12-bit sample zero-extended on data_out with a one-cycle valid pulse.
// Each BUSY edge is waited for at most TIMEOUT+1 cycles; a timeout sets the
// sticky err flag and returns to idle without producing a sample.
//
// Ports:
//   clk, rst  : system clock; synchronous active-high reset
//   host      : command/result bus (slave modport)
//   CONVST_N  : ADC convert start, active-low
//   CS_N      : ADC chip select, active-low
//   RD_N      : ADC read strobe, active-low
//   A0        : ADC channel select
//   BUSY      : ADC busy, asynchronous to clk
//   DB        : ADC parallel data
//
// Parameters:
//   T_CONVST  : cycles CONVST_N is held low (>=1)
//   T_RD      : cycles RD_N is held low before DB is sampled (>=1)
//   TIMEOUT   : last counter value tolerated while waiting on BUSY (<=255)
// ---------------------------------------------------------------------------
module adc_interface_ad7862
    import adc_interface_ad7862_pkg::*;
#(
    parameter int unsigned T_CONVST = T_CONVST_DEF,
    parameter int unsigned T_RD     = T_RD_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    adc_interface_ad7862_if.slave  host,
    output logic                   CONVST_N,
    output logic                   CS_N,
    output logic                   RD_N,
    output logic                   A0,
    input  logic                   BUSY,
    input  logic [DB_W-1:0]        DB
);

    // Counter compare points, pre-sized to the counter width.
    localparam logic [CNT_W-1:0] CONVST_LAST = CNT_W'(T_CONVST - 1);
    localparam logic [CNT_W-1:0] RD_SAMPLE   = CNT_W'(1 + T_RD);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    adc_state_e          state_q,    state_d;
    logic [CNT_W-1:0]    counter_q,  counter_d;
    logic                convst_n_q, convst_n_d;
    logic                cs_n_q,     cs_n_d;
    logic                rd_n_q,     rd_n_d;
    logic                a0_q,       a0_d;
    logic                rdy_q,      rdy_d;
    logic                valid_q,    valid_d;
    logic                err_q,      err_d;
    logic [DATA_W-1:0]   data_q,     data_d;

    logic int_rst;
    logic start;
    logic busy_s;
    logic unused_bits;

    // A soft reset on the command strobe behaves exactly like rst, and
    // wins over a start presented in the same cycle.
    assign int_rst = rst | (host.cs & host.op[OP_SOFT_RST_BIT]);
    assign start   = host.cs & host.op[OP_START_BIT];

    // Opcode and address bits that carry no meaning for this block.
    assign unused_bits = ^{host.op[OP_W-1:2], host.addr[ADDR_W-1:1]};

    // The FSM only ever looks at the synchronized copy of BUSY.
    sync2 u_busy_sync (
        .clk (clk),
        .rst (int_rst),
        .d   (BUSY),
        .q   (busy_s)
    );

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        convst_n_d = convst_n_q;
        cs_n_d     = cs_n_q;
        rd_n_d     = rd_n_q;
        a0_d       = a0_q;
        rdy_d      = rdy_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        data_d     = data_q;

        unique case (state_q)
            ST_RESET: begin
                rdy_d   = 1'b1;
                state_d = ST_IDLE;
            end

            ST_IDLE: begin
                // Starts are only honoured here; there is no queue.
                if (start) begin
                    a0_d       = host.addr[0];
                    convst_n_d = 1'b0;
                    rdy_d      = 1'b0;
                    err_d      = 1'b0;
                    state_d    = ST_CONV;
                end
            end

            ST_CONV: begin
                if (counter_q == CONVST_LAST) begin
                    convst_n_d = 1'b1;
                    state_d    = ST_WAIT_HI;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end

            // A BUSY that is already high here (a previous conversion still
            // running) is taken as the rising edge.
            ST_WAIT_HI: begin
                if (busy_s) begin
                    state_d = ST_WAIT_LO;
                end else if (counter_q == TIMEOUT_CNT) begin
                    state_d = ST_ERR;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end

            ST_WAIT_LO: begin
                if (!busy_s) begin
                    state_d = ST_READ;
                end else if (counter_q == TIMEOUT_CNT) begin
                    state_d = ST_ERR;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end

            // CS_N drops one cycle ahead of RD_N; DB is captured after RD_N
            // has been low for T_RD cycles, so RD_N always sits inside CS_N.
            ST_READ: begin
                if (counter_q == '0) begin
                    cs_n_d = 1'b0;
                end
                if (counter_q == CNT_W'(1)) begin
                    rd_n_d = 1'b0;
                end
                if (counter_q == RD_SAMPLE) begin
                    data_d  = zext_sample(DB);
                    rd_n_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end

            ST_DONE: begin
                cs_n_d  = 1'b1;
                valid_d = 1'b1;
                rdy_d   = 1'b1;
                state_d = ST_IDLE;
            end

            ST_ERR: begin
                err_d      = 1'b1;
                rdy_d      = 1'b1;
                convst_n_d = 1'b1;
                cs_n_d     = 1'b1;
                rd_n_d     = 1'b1;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_RESET;
            end
        endcase

        // Every state change starts the next phase from a zero count.
        if (state_d != state_q) begin
            counter_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (int_rst) begin
            state_q    <= ST_RESET;
            counter_q  <= '0;
            convst_n_q <= 1'b1;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            a0_q       <= 1'b0;
            rdy_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            convst_n_q <= convst_n_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            a0_q       <= a0_d;
            rdy_q      <= rdy_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            data_q     <= data_d;
        end
    end

    assign CONVST_N      = convst_n_q;
    assign CS_N          = cs_n_q;
    assign RD_N          = rd_n_q;
    assign A0            = a0_q;
    assign host.rdy      = rdy_q;
    assign host.valid    = valid_q;
    assign host.err      = err_q;
    assign host.state    = state_q;
    assign host.data_out = data_q;

endmodule

// File: tb/tb_adc_interface_ad7862.sv
// ---------------------------------------------------------------------------
// tb_adc_interface_ad7862
//
// Self-checking bench for adc_interface_ad7862. A small behavioural ADC
// raises BUSY on each CONVST_N rising edge and holds it for a configurable
// number of cycles (or never / forever). Normal reads come from a table of
// directed vectors; timeouts, start-while-busy and soft reset are written
// out as explicit sequences.
// ---------------------------------------------------------------------------
module tb_adc_interface_ad7862;
    import adc_interface_ad7862_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        convst_n;
    logic        cs_n;
    logic        rd_n;
    logic        a0;
    logic        adc_busy = 1'b0;
    logic [11:0] adc_db;

    adc_interface_ad7862_if host_if ();

    adc_interface_ad7862 dut (
        .clk      (clk),
        .rst      (rst),
        .host     (host_if),
        .CONVST_N (convst_n),
        .CS_N     (cs_n),
        .RD_N     (rd_n),
        .A0       (a0),
        .BUSY     (adc_busy),
        .DB       (adc_db)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // ADC model configuration, written only by the main sequence.
    int   cfg_busy_len = 10;
    logic cfg_stuck_lo = 1'b0;
    logic cfg_stuck_hi = 1'b0;

    // Behavioural ADC: BUSY rises on the CONVST_N rising edge.
    logic convst_prev = 1'b1;
    int   busy_left   = 0;
    always @(negedge clk) begin
        if (busy_left > 0) busy_left = busy_left - 1;
        if (busy_left == 0 && !cfg_stuck_hi) adc_busy = 1'b0;
        if (convst_prev === 1'b0 && convst_n === 1'b1 && !cfg_stuck_lo) begin
            adc_busy  = 1'b1;
            busy_left = cfg_busy_len;
        end
        convst_prev = convst_n;
    end

    // Strobe monitor: pulse counts and low-phase widths.
    int valid_count   = 0;
    int convst_run    = 0;
    int convst_last   = 0;
    int rd_run        = 0;
    int rd_last       = 0;
    int rd_outside_cs = 0;
    always @(negedge clk) begin
        if (host_if.valid === 1'b1) valid_count = valid_count + 1;
        if (convst_n === 1'b0) convst_run = convst_run + 1;
        else if (convst_run != 0) begin
            convst_last = convst_run;
            convst_run  = 0;
        end
        if (rd_n === 1'b0) rd_run = rd_run + 1;
        else if (rd_run != 0) begin
            rd_last = rd_run;
            rd_run  = 0;
        end
        if (rd_n === 1'b0 && cs_n !== 1'b0) rd_outside_cs = rd_outside_cs + 1;
    end

    typedef struct {
        logic [7:0]  addr;
        int          busy_len;
        logic [11:0] db;
        logic        exp_a0;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[4];

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks_total = checks_total + 1;
        if (actual === expected) checks_passed = checks_passed + 1;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Presents one command for one cycle; called and returns on a negedge.
    task automatic sendCmd(input logic [3:0] op, input logic [7:0] addr);
        host_if.cs   = 1'b1;
        host_if.op   = op;
        host_if.addr = addr;
        @(negedge clk);
        host_if.cs   = 1'b0;
        host_if.op   = 4'h0;
        host_if.addr = 8'h00;
    endtask

    task automatic waitValid(input int limit, output int lat);
        lat = 0;
        while (host_if.valid !== 1'b1 && lat < limit) begin
            @(negedge clk);
            lat = lat + 1;
        end
    endtask

    task automatic waitErr(input int limit, output int lat);
        lat = 0;
        while (host_if.err !== 1'b1 && lat < limit) begin
            @(negedge clk);
            lat = lat + 1;
        end
    endtask

    task automatic waitState(input logic [3:0] st, input int limit, output logic ok);
        int n = 0;
        while (host_if.state !== st && n < limit) begin
            @(negedge clk);
            n = n + 1;
        end
        ok = (host_if.state === st);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int vc;
        int ro;
        int lat;
        string tag;
        tag = $sformatf("vec%0d", idx);
        adc_db       = v.db;
        cfg_busy_len = v.busy_len;
        vc = valid_count;
        ro = rd_outside_cs;
        sendCmd(4'b0010, v.addr);
        checkOutput({tag, " a0"}, 16'(a0), 16'(v.exp_a0));
        checkOutput({tag, " rdy low"}, 16'(host_if.rdy), 16'h0);
        waitValid(200, lat);
        checkOutput({tag, " latency"}, 16'(lat), 16'(v.exp_lat));
        checkOutput({tag, " data_out"}, host_if.data_out, v.exp_data);
        checkOutput({tag, " rdy with valid"}, 16'(host_if.rdy), 16'h1);
        repeat (5) @(negedge clk);
        checkOutput({tag, " valid pulses"}, 16'(valid_count - vc), 16'h1);
        checkOutput({tag, " convst width"}, 16'(convst_last), 16'd2);
        checkOutput({tag, " rd width"}, 16'(rd_last), 16'd3);
        checkOutput({tag, " rd inside cs"}, 16'(rd_outside_cs - ro), 16'h0);
        checkOutput({tag, " err"}, 16'(host_if.err), 16'h0);
        checkOutput({tag, " idle"}, 16'(host_if.state), 16'(ST_IDLE));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   lat;
        int   vc;
        logic ok;

        vecs[0] = '{8'hFE, 3,  12'hFFF, 1'b0, 16'h0FFF, 14};
        vecs[1] = '{8'h03, 1,  12'h000, 1'b1, 16'h0000, 12};
        vecs[2] = '{8'h80, 20, 12'h7E1, 1'b0, 16'h07E1, 31};
        vecs[3] = '{8'h01, 10, 12'hA5C, 1'b1, 16'h0A5C, 21};

        rst          = 1'b1;
        host_if.cs   = 1'b0;
        host_if.op   = 4'h0;
        host_if.addr = 8'h00;
        adc_db       = 12'h000;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset convst_n", 16'(convst_n), 16'h1);
        checkOutput("reset cs_n", 16'(cs_n), 16'h1);
        checkOutput("reset rd_n", 16'(rd_n), 16'h1);
        checkOutput("reset a0", 16'(a0), 16'h0);
        checkOutput("reset rdy", 16'(host_if.rdy), 16'h0);
        checkOutput("reset valid", 16'(host_if.valid), 16'h0);
        checkOutput("reset err", 16'(host_if.err), 16'h0);
        checkOutput("reset data_out", host_if.data_out, 16'h0000);
        checkOutput("reset state", 16'(host_if.state), 16'(ST_RESET));
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset rdy", 16'(host_if.rdy), 16'h1);
        checkOutput("post-reset state", 16'(host_if.state), 16'(ST_IDLE));

        // Normal reads.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i], i);
        end

        // BUSY never rises: WAIT_HI timeout.
        cfg_stuck_lo = 1'b1;
        vc = valid_count;
        sendCmd(4'b0010, 8'h00);
        waitErr(400, lat);
        checkOutput("wait_hi timeout latency", 16'(lat), 16'd259);
        checkOutput("wait_hi timeout err", 16'(host_if.err), 16'h1);
        checkOutput("wait_hi timeout rdy", 16'(host_if.rdy), 16'h1);
        checkOutput("wait_hi timeout state", 16'(host_if.state), 16'(ST_IDLE));
        checkOutput("wait_hi timeout data kept", host_if.data_out, 16'h0A5C);
        repeat (3) @(negedge clk);
        checkOutput("wait_hi timeout no valid", 16'(valid_count - vc), 16'h0);
        checkOutput("wait_hi timeout err sticky", 16'(host_if.err), 16'h1);
        cfg_stuck_lo = 1'b0;

        // BUSY never falls: WAIT_LO timeout, then recovery.
        cfg_stuck_hi = 1'b1;
        vc = valid_count;
        sendCmd(4'b0010, 8'h01);
        checkOutput("accept clears err", 16'(host_if.err), 16'h0);
        waitErr(400, lat);
        checkOutput("wait_lo timeout latency", 16'(lat), 16'd262);
        checkOutput("wait_lo timeout rdy", 16'(host_if.rdy), 16'h1);
        checkOutput("wait_lo timeout data kept", host_if.data_out, 16'h0A5C);
        checkOutput("wait_lo timeout strobes", 16'({convst_n, cs_n, rd_n}), 16'h7);
        checkOutput("wait_lo timeout no valid", 16'(valid_count - vc), 16'h0);
        cfg_stuck_hi = 1'b0;
        repeat (4) @(negedge clk);
        adc_db       = 12'h123;
        cfg_busy_len = 5;
        sendCmd(4'b0010, 8'h00);
        checkOutput("restart clears err", 16'(host_if.err), 16'h0);
        checkOutput("restart a0", 16'(a0), 16'h0);
        waitValid(200, lat);
        checkOutput("restart latency", 16'(lat), 16'd16);
        checkOutput("restart data_out", host_if.data_out, 16'h0123);
        repeat (3) @(negedge clk);

        // Second start during WAIT_LO is ignored.
        adc_db       = 12'h456;
        cfg_busy_len = 12;
        vc = valid_count;
        sendCmd(4'b0010, 8'h01);
        waitState(4'(ST_WAIT_LO), 50, ok);
        checkOutput("reach wait_lo", 16'(ok), 16'h1);
        sendCmd(4'b0010, 8'h00);
        checkOutput("ignored start state", 16'(host_if.state), 16'(ST_WAIT_LO));
        checkOutput("ignored start a0", 16'(a0), 16'h1);
        waitValid(200, lat);
        checkOutput("busy-start data_out", host_if.data_out, 16'h0456);
        repeat (5) @(negedge clk);
        checkOutput("busy-start single valid", 16'(valid_count - vc), 16'h1);

        // Soft reset while CS_N is low.
        adc_db       = 12'h789;
        cfg_busy_len = 4;
        vc = valid_count;
        sendCmd(4'b0010, 8'h01);
        lat = 0;
        while (cs_n !== 1'b0 && lat < 60) begin
            @(negedge clk);
            lat = lat + 1;
        end
        checkOutput("reach read cs_n low", 16'(cs_n), 16'h0);
        sendCmd(4'b0011, 8'h00);
        checkOutput("soft reset cs_n", 16'(cs_n), 16'h1);
        checkOutput("soft reset rd_n", 16'(rd_n), 16'h1);
        checkOutput("soft reset convst_n", 16'(convst_n), 16'h1);
        checkOutput("soft reset a0", 16'(a0), 16'h0);
        checkOutput("soft reset state", 16'(host_if.state), 16'(ST_RESET));
        checkOutput("soft reset data_out", host_if.data_out, 16'h0000);
        checkOutput("soft reset rdy", 16'(host_if.rdy), 16'h0);
        @(negedge clk);
        checkOutput("after soft reset state", 16'(host_if.state), 16'(ST_IDLE));
        checkOutput("after soft reset rdy", 16'(host_if.rdy), 16'h1);
        repeat (10) @(negedge clk);
        checkOutput("soft reset no valid", 16'(valid_count - vc), 16'h0);
        checkOutput("soft reset data stays 0", host_if.data_out, 16'h0000);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
